// File: rtl/argmax_sequencer.sv
// argmax_sequencer: streams per-class scores into an argmax_cell and queues the winning indices
//
// Ports:
//   clk, rst_n    clock (posedge) and asynchronous active-low reset
//   flush         synchronous abort of the partial vector; queued and pending results are dropped
//   in_value      score for the current class, qualified by in_valid
//   in_valid      in_value valid
//   in_ready      a score is accepted when in_valid && in_ready
//   cell_index    class index driven to the argmax_cell
//   cell_value    score driven to the argmax_cell
//   cell_enable   argmax_cell input enable
//   cell_result   argmax_cell result; MSB flags a finished vector
//   res_index     winning class index at the result FIFO head
//   res_valid     result FIFO non-empty
//   res_ready     downstream pops the head
//   vec_count     completed vectors, wraps at 2^16
//   busy          partial vector in progress or result still pending
module argmax_sequencer #(
    parameter int DATA_WIDTH    = 32,
    parameter int WEIGHT_AMOUNT = 4,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] in_value,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] cell_index,
    output logic [DATA_WIDTH-1:0] cell_value,
    output logic                  cell_enable,
    input  logic [DATA_WIDTH:0]   cell_result,
    output logic [DATA_WIDTH-1:0] res_index,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [15:0]           vec_count,
    output logic                  busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [DATA_WIDTH-1:0] LAST_IDX = DATA_WIDTH'(WEIGHT_AMOUNT - 1);
    localparam logic [CW:0] DEPTH = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, FILL} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] idx;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         fifo_count;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic                  beat;
    logic                  first;
    logic                  last;
    logic                  capture;
    logic                  pop;
    logic [CW:0]           credit_used;

    // A new vector may only start if its result is guaranteed a FIFO slot,
    // counting both queued results and vectors still in flight.
    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
    assign in_ready    = rst_n && (state == FILL || credit_used < DEPTH);
    assign beat        = in_valid && in_ready;
    assign first       = beat && idx == '0;
    assign last        = beat && idx == LAST_IDX;
    assign capture     = cell_result[DATA_WIDTH] && outstanding != '0;
    assign res_valid   = fifo_count != '0;
    assign pop         = res_valid && res_ready;
    assign res_index   = mem[rd_ptr];
    assign busy        = state == FILL || outstanding != '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cell_index  <= '0;
            cell_value  <= '0;
            cell_enable <= 1'b0;
            vec_count   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            state       <= IDLE;
            idx         <= '0;
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cell_enable <= 1'b0;
        end else begin
            cell_enable <= beat;
            if (beat) begin
                cell_index <= idx;
                cell_value <= in_value;
                idx        <= last ? '0 : idx + 1'b1;
            end
            state       <= last ? IDLE : first ? FILL : state;
            outstanding <= outstanding + CW'(first) - CW'(capture);
            fifo_count  <= fifo_count + CW'(capture) - CW'(pop);
            if (capture) begin
                mem[wr_ptr] <= cell_result[DATA_WIDTH-1:0];
                wr_ptr      <= wr_ptr + 1'b1;
                vec_count   <= vec_count + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule
